// File: rtl/adder_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined add/subtract unit.
package adder_pipe_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Operands must split into equal, non-empty chunks.
    function automatic bit width_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_pipe_n_if.sv
// Operand/result handshake bundle for adder_pipe_n; master drives operands, slave is the unit.
interface adder_pipe_n_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/adder_chunk.sv
// C-bit combinational adder slice used by every pipeline stage.
module adder_chunk #(
    parameter int C = 4
) (
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         cin,
    output logic [C-1:0] s,
    output logic         co
);
    logic [C:0] t_s;

    assign t_s = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, cin};
    assign s   = t_s[C-1:0];
    assign co  = t_s[C];
endmodule

// File: rtl/adder_pipe_n.sv
// Pipelined add/subtract unit: WIDTH-bit operands split over STAGES chunk stages, carry ripples one stage per cycle.
// Optional macro ADDER_PIPE_SAT_EN clamps signed-overflowing results to signed max/min.
module adder_pipe_n
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    adder_pipe_n_if.slave bus
);
    localparam int C    = chunk_w(WIDTH, STAGES);
    localparam int MSB  = WIDTH - 1;
    localparam int LAST = STAGES - 1;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    if (!width_ok(WIDTH, STAGES)) begin : gen_bad_cfg
        $error("adder_pipe_n: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    // Stage boundary k feeds stage k; boundary 0 is the operand port.
    logic [STAGES-1:0][WIDTH-1:0] a_p_s;
    logic [STAGES-1:0][WIDTH-1:0] b_p_s;
    logic [STAGES-1:0][WIDTH-1:0] res_p_s;
    logic [STAGES-1:0]            sub_p_s;
    logic [STAGES-1:0]            c_p_s;
    logic [STAGES-1:0]            v_p_s;
    logic [STAGES:0]              load_s;

    assign a_p_s[0]       = bus.a;
    assign b_p_s[0]       = bus.b;
    assign res_p_s[0]     = {WIDTH{1'b0}};
    assign sub_p_s[0]     = (op_e'(bus.sub) == OP_SUB);
    assign c_p_s[0]       = bus.cin ^ sub_p_s[0];
    assign v_p_s[0]       = bus.in_valid;
    assign load_s[STAGES] = bus.out_ready;
    assign bus.in_ready   = load_s[0];

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        logic [C-1:0]     b_eff_s;
        logic [C-1:0]     s_s;
        logic             co_s;
        logic [WIDTH-1:0] res_s;

        assign b_eff_s = b_p_s[k][k*C +: C] ^ {C{sub_p_s[k]}};

        adder_chunk #(.C(C)) u_chunk (
            .a   (a_p_s[k][k*C +: C]),
            .b   (b_eff_s),
            .cin (c_p_s[k]),
            .s   (s_s),
            .co  (co_s)
        );

        // Splice this stage's chunk into the partial result carried from below.
        always_comb begin
            res_s          = res_p_s[k];
            res_s[k*C +: C] = s_s;
        end

        if (k < LAST) begin : gen_mid
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;
            logic [WIDTH-1:0] res_r;
            logic             sub_r;
            logic             c_r;
            logic             v_r;

            assign load_s[k] = !v_r || load_s[k+1];

            // Intermediate stage register: data only moves with a valid beat.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_r   <= 1'b0;
                    a_r   <= {WIDTH{1'b0}};
                    b_r   <= {WIDTH{1'b0}};
                    res_r <= {WIDTH{1'b0}};
                    sub_r <= 1'b0;
                    c_r   <= 1'b0;
                end else if (load_s[k]) begin
                    v_r <= v_p_s[k];
                    if (v_p_s[k]) begin
                        a_r   <= a_p_s[k];
                        b_r   <= b_p_s[k];
                        res_r <= res_s;
                        sub_r <= sub_p_s[k];
                        c_r   <= co_s;
                    end
                end
            end

            assign a_p_s[k+1]   = a_r;
            assign b_p_s[k+1]   = b_r;
            assign res_p_s[k+1] = res_r;
            assign sub_p_s[k+1] = sub_r;
            assign c_p_s[k+1]   = c_r;
            assign v_p_s[k+1]   = v_r;
        end else begin : gen_last
            logic             ovf_s;
            logic [WIDTH-1:0] sum_s;

            assign load_s[k] = !bus.out_valid || load_s[k+1];

            // Signed overflow and optional clamp, ahead of the output register.
            always_comb begin
                ovf_s = (a_p_s[k][MSB] == b_eff_s[C-1]) && (res_s[MSB] != a_p_s[k][MSB]);
`ifdef ADDER_PIPE_SAT_EN
                if (ovf_s) begin
                    sum_s = a_p_s[k][MSB] ? SMIN : SMAX;
                end else begin
                    sum_s = res_s;
                end
`else
                sum_s = res_s;
`endif
            end

            // Output register: holds its beat while the consumer stalls.
            always_ff @(posedge clk) begin
                if (rst) begin
                    bus.out_valid <= 1'b0;
                    bus.sum       <= {WIDTH{1'b0}};
                    bus.cout      <= 1'b0;
                    bus.ovf       <= 1'b0;
                    bus.zero      <= 1'b0;
                end else if (load_s[k]) begin
                    bus.out_valid <= v_p_s[k];
                    if (v_p_s[k]) begin
                        bus.sum  <= sum_s;
                        bus.cout <= co_s;
                        bus.ovf  <= ovf_s;
                        bus.zero <= (sum_s == {WIDTH{1'b0}});
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_pipe_n.sv
// Directed-vector bench for adder_pipe_n (WIDTH=8, STAGES=2) with a result scoreboard.
module tb_adder_pipe_n;
    localparam int W = 8;
    localparam int S = 2;
`ifdef ADDER_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    exp_t exp_q[$];

    adder_pipe_n_if #(.WIDTH(W)) bus ();

    adder_pipe_n #(.WIDTH(W), .STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] s, input logic c, input logic o, input logic z);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.zero = z;
        exp_q.push_back(e);
    endtask

    // Whole-width reference used only for the random sweep.
    function automatic exp_t ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   t;
        be     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? ~cin : cin)};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (a[W-1] == be[W-1]) && (e.sum[W-1] != a[W-1]);
        if (SAT && e.ovf) e.sum = a[W-1] ? 8'h80 : 8'h7F;
        e.zero = (e.sum == 8'h00);
        return e;
    endfunction

    // Enters and leaves at posedge+1; in_valid stays high on exit.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        bit acc = 1'b0;
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
        end
        chk("accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk(tag, exp_q.size(), 32'd0);
    endtask

    // Scoreboard: every emitted beat must match the oldest expectation; stalled outputs must show it too.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid) begin
            chk("beat_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk(bus.out_ready ? "sum" : "stall_sum", {24'd0, bus.sum}, {24'd0, e.sum});
                chk("cout", {31'd0, bus.cout}, {31'd0, e.cout});
                chk("ovf",  {31'd0, bus.ovf},  {31'd0, e.ovf});
                chk("zero", {31'd0, bus.zero}, {31'd0, e.zero});
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_sum",       {24'd0, bus.sum},       32'd0);
        chk("rst_cout",      {31'd0, bus.cout},      32'd0);
        chk("rst_ovf",       {31'd0, bus.ovf},       32'd0);
        chk("rst_zero",      {31'd0, bus.zero},      32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(posedge clk); #1;

        // FF + 01: latency exactly two cycles.
        push(8'h00, 1'b1, 1'b0, 1'b1);
        send(8'hFF, 8'h01, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_not_early", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_on_time", {31'd0, bus.out_valid}, 32'd1);
        @(posedge clk); #1;
        drain("drain_first");

        // Directed arithmetic vectors, back to back.
        push(SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1, 1'b0);   send(8'h80, 8'h01, 1'b0, 1'b1);
        push(8'hFD, 1'b0, 1'b0, 1'b0);                 send(8'h05, 8'h07, 1'b1, 1'b1);
        push(SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, 1'b0);   send(8'h7F, 8'h01, 1'b0, 1'b0);
        push(8'h47, 1'b0, 1'b0, 1'b0);                 send(8'h12, 8'h34, 1'b1, 1'b0);
        push(8'h00, 1'b1, 1'b0, 1'b1);                 send(8'h00, 8'h00, 1'b0, 1'b1);
        push(SAT ? 8'h80 : 8'h00, 1'b1, 1'b1, !SAT);   send(8'h80, 8'h80, 1'b0, 1'b0);
        push(8'h10, 1'b0, 1'b0, 1'b0);                 send(8'h0F, 8'h01, 1'b0, 1'b0);
        push(8'h00, 1'b1, 1'b0, 1'b1);                 send(8'h0F, 8'hF0, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        drain("drain_directed");

        // Backpressure: five beats, consumer stalled four cycles.
        bus.out_ready = 1'b0;
        push(8'h02, 1'b0, 1'b0, 1'b0);
        push(8'h30, 1'b0, 1'b0, 1'b0);
        push(8'h22, 1'b1, 1'b0, 1'b0);
        push(8'h00, 1'b1, 1'b0, 1'b1);
        push(SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, 1'b0);
        fork
            begin
                send(8'h01, 8'h01, 1'b0, 1'b0);
                send(8'h10, 8'h20, 1'b0, 1'b0);
                send(8'h33, 8'h11, 1'b0, 1'b1);
                send(8'hFE, 8'h01, 1'b1, 1'b0);
                send(8'h40, 8'h40, 1'b0, 1'b0);
                bus.in_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                chk("in_ready_full", {31'd0, bus.in_ready}, 32'd0);
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain("drain_stall");

        // Reset with two beats in flight: neither may appear.
        bus.out_ready = 1'b0;
        push(8'h11, 1'b0, 1'b0, 1'b0); send(8'h10, 8'h01, 1'b0, 1'b0);
        push(8'h22, 1'b0, 1'b0, 1'b0); send(8'h20, 8'h02, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        push(8'h69, 1'b0, 1'b0, 1'b0);
        send(8'h5A, 8'h0F, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        drain("drain_after_reset");

        // Random sweep against the whole-width reference.
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc, rs;
            ra = W'($urandom_range(255, 0));
            rb = W'($urandom_range(255, 0));
            rc = 1'($urandom_range(1, 0));
            rs = 1'($urandom_range(1, 0));
            exp_q.push_back(ref_calc(ra, rb, rc, rs));
            send(ra, rb, rc, rs);
        end
        bus.in_valid = 1'b0;
        drain("drain_random");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
